// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_pkg
// Description : Shared types, widths and the lowest-set-bit search used by
//               the ADC scan sequencer and its priority finder.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_scan_pkg;

   // Widest mask the search function handles; narrower masks are zero-padded
   localparam int MAX_CH = 16;
   // Search result width: holds 0..MAX_CH, where MAX_CH means "nothing found"
   localparam int SEL_W  = 5;
   // ADC command/response channel field width
   localparam int CH_W   = 5;
   // ADC conversion result width
   localparam int DATA_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PICK = 3'd1,
      ST_CMD  = 3'd2,
      ST_WAIT = 3'd3,
      ST_EMIT = 3'd4
   } scan_state_t;

   // Index of the lowest set bit at or above start; MAX_CH when none remain
   function automatic logic [SEL_W-1:0] lowest_set_from(
      input logic [MAX_CH-1:0] mask,
      input logic [SEL_W-1:0]  start
   );
      logic [SEL_W-1:0] sel;
      sel = SEL_W'(MAX_CH);
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(start))) begin
            sel = SEL_W'(i);
         end
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_pick.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_pick
// Description : Combinational priority finder: lowest set mask bit whose
//               index is at or above a start index. A start index at or past
//               the mask width always reports "not found".
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_pick
   import adc_scan_pkg::*;
#(
   parameter  int N     = 8,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
)(
   input  logic [N-1:0]     mask,
   input  logic [IDX_W:0]   start,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   logic [MAX_CH-1:0] mask_ext;
   logic [SEL_W-1:0]  start_ext;
   logic [SEL_W-1:0]  sel;

   // Widen to the package search width and decode the search result
   always_comb begin
      mask_ext            = '0;
      mask_ext[N-1:0]     = mask;
      start_ext           = '0;
      start_ext[IDX_W:0]  = start;
      sel                 = lowest_set_from(mask_ext, start_ext);
      found               = (sel != SEL_W'(MAX_CH));
      index               = sel[IDX_W-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Autonomous scan sequencer for the modular ADC command /
//               response interface. Walks a latched channel mask in ascending
//               order, issues single-sample commands, averages 2^AVG_LOG2
//               matching responses per channel and emits one result per
//               channel per scan. Unanswered samples are abandoned after
//               TIMEOUT cycles and flagged in a sticky error bit.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl
   import adc_scan_pkg::*;
#(
   parameter  int NUM_CH    = 8,
   parameter  int CH_OFFSET = 1,
   parameter  int AVG_LOG2  = 2,
   parameter  int TIMEOUT   = 255,
   localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              err_clear,
   output logic              cmd_valid,
   output logic [CH_W-1:0]   cmd_channel,
   output logic              cmd_sop,
   output logic              cmd_eop,
   input  logic              cmd_ready,
   input  logic              rsp_valid,
   input  logic [CH_W-1:0]   rsp_channel,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              result_valid,
   output logic [IDX_W-1:0]  result_index,
   output logic [DATA_W-1:0] result_data,
   output logic              scan_done,
   output logic              busy,
   output logic              err_timeout
);

   localparam int ACC_W  = DATA_W + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;
   localparam int TM_W   = $clog2(TIMEOUT + 1);
   // One extra bit lets idx step past the last channel without wrapping
   localparam int SIDX_W = IDX_W + 1;

   scan_state_t       state;
   logic [NUM_CH-1:0] mask_l;
   logic [SIDX_W-1:0] idx;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic [TM_W-1:0]   timer;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_index;
   logic [ACC_W-1:0]  acc_sum;
   logic [CNT_W-1:0]  cnt_inc;
   logic              rsp_match;

   // Single-beat packets: start and end of packet track valid directly
   assign cmd_sop = cmd_valid;
   assign cmd_eop = cmd_valid;

   adc_scan_pick #(
      .N      (NUM_CH)
   ) u_pick (
      .mask   (mask_l),
      .start  (idx),
      .found  (pick_found),
      .index  (pick_index)
   );

   // Next accumulator/count values and response match against the issued channel
   always_comb begin
      acc_sum   = acc + ACC_W'(rsp_data);
      cnt_inc   = cnt + CNT_W'(1);
      rsp_match = rsp_valid && (rsp_channel == cmd_channel);
   end

   // Scan sequencer with registered command, result and status outputs
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state        <= ST_IDLE;
         mask_l       <= '0;
         idx          <= '0;
         acc          <= '0;
         cnt          <= '0;
         timer        <= '0;
         cmd_valid    <= 1'b0;
         cmd_channel  <= '0;
         result_valid <= 1'b0;
         result_index <= '0;
         result_data  <= '0;
         scan_done    <= 1'b0;
         busy         <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         scan_done    <= 1'b0;
         // A timeout later in this block overrides the clear
         if (err_clear) begin
            err_timeout <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (enable && (ch_mask != '0)) begin
                  mask_l <= ch_mask;
                  idx    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_PICK;
               end
            end

            ST_PICK: begin
               if (!enable) begin
                  // Abandoned scan: finish quietly without scan_done
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (pick_found) begin
                  idx         <= SIDX_W'(pick_index);
                  acc         <= '0;
                  cnt         <= '0;
                  cmd_valid   <= 1'b1;
                  cmd_channel <= CH_W'(pick_index) + CH_W'(CH_OFFSET);
                  state       <= ST_CMD;
               end else begin
                  scan_done <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            ST_CMD: begin
               // Command fields stay frozen until the ADC accepts them
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  timer     <= '0;
                  state     <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               timer <= timer + TM_W'(1);
               if (rsp_match) begin
                  acc <= acc_sum;
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_W'(2 ** AVG_LOG2)) begin
                     result_valid <= 1'b1;
                     result_index <= idx[IDX_W-1:0];
                     result_data  <= acc_sum[ACC_W-1:AVG_LOG2];
                     state        <= ST_EMIT;
                  end else begin
                     cmd_valid <= 1'b1;
                     state     <= ST_CMD;
                  end
               end else if (timer == TM_W'(TIMEOUT)) begin
                  // Give up on this channel entirely; no partial result
                  err_timeout <= 1'b1;
                  acc         <= '0;
                  cnt         <= '0;
                  idx         <= idx + SIDX_W'(1);
                  state       <= ST_PICK;
               end
            end

            ST_EMIT: begin
               idx   <= idx + SIDX_W'(1);
               state <= ST_PICK;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_ctrl
// Description : Directed self-checking bench for adc_scan_ctrl with a simple
//               ADC responder (fixed latency, optional dropped channel and
//               optional stray response on channel 7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;

   localparam int RSP_LAT = 3;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        enable;
   logic [7:0]  ch_mask;
   logic        err_clear;
   logic        cmd_valid;
   logic [4:0]  cmd_channel;
   logic        cmd_sop;
   logic        cmd_eop;
   logic        cmd_ready;
   logic        rsp_valid   = 1'b0;
   logic [4:0]  rsp_channel = '0;
   logic [11:0] rsp_data    = '0;
   logic        result_valid;
   logic [2:0]  result_index;
   logic [11:0] result_data;
   logic        scan_done;
   logic        busy;
   logic        err_timeout;

   adc_scan_ctrl #(
      .NUM_CH    (8),
      .CH_OFFSET (1),
      .AVG_LOG2  (2),
      .TIMEOUT   (255)
   ) dut (
      .clk_clk      (clk_clk),
      .reset_reset  (reset_reset),
      .enable       (enable),
      .ch_mask      (ch_mask),
      .err_clear    (err_clear),
      .cmd_valid    (cmd_valid),
      .cmd_channel  (cmd_channel),
      .cmd_sop      (cmd_sop),
      .cmd_eop      (cmd_eop),
      .cmd_ready    (cmd_ready),
      .rsp_valid    (rsp_valid),
      .rsp_channel  (rsp_channel),
      .rsp_data     (rsp_data),
      .result_valid (result_valid),
      .result_index (result_index),
      .result_data  (result_data),
      .scan_done    (scan_done),
      .busy         (busy),
      .err_timeout  (err_timeout)
   );

   always #5 clk_clk = ~clk_clk;

   int errors = 0;
   int checks = 0;

   // responder / monitor state
   logic [11:0] data_q[$];
   logic [15:0] res_q[$];
   logic [4:0]  cmd_log[$];
   logic [4:0]  drop_ch  = 5'd0;
   logic        stray_en = 1'b0;
   logic [4:0]  pend_ch  = 5'd0;
   int          rsp_timer = 0;
   int          rsp_sent  = 0;
   int          accepted  = 0;
   int          done_cnt  = 0;
   int          sop_bad   = 0;
   int          cyc       = 0;
   int          hs_cyc    = 0;
   int          err_cyc   = 0;
   logic        err_seen  = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clk_clk) cyc++;

   // Monitor: handshakes, results, done pulses, first error time
   always @(negedge clk_clk) begin
      if (cmd_valid && cmd_ready) begin
         accepted++;
         cmd_log.push_back(cmd_channel);
         if (cmd_channel == drop_ch) hs_cyc = cyc;
         pend_ch   = cmd_channel;
         rsp_timer = RSP_LAT;
      end
      if ((cmd_sop !== cmd_valid) || (cmd_eop !== cmd_valid)) sop_bad++;
      if (result_valid) res_q.push_back({1'b0, result_index, result_data});
      if (scan_done) done_cnt++;
      if (err_timeout && !err_seen) begin
         err_seen = 1'b1;
         err_cyc  = cyc;
      end
   end

   // ADC model: answers each accepted command RSP_LAT cycles later
   always begin
      @(posedge clk_clk);
      #1;
      rsp_valid = 1'b0;
      if (rsp_timer > 0) begin
         rsp_timer--;
         if (rsp_timer == 1 && stray_en) begin
            rsp_valid   = 1'b1;
            rsp_channel = 5'd7;
            rsp_data    = 12'hABC;
         end else if (rsp_timer == 0 && pend_ch != drop_ch) begin
            rsp_valid   = 1'b1;
            rsp_channel = pend_ch;
            rsp_data    = (data_q.size() > 0) ? data_q.pop_front() : 12'h000;
            rsp_sent++;
         end
      end
   end

   function automatic logic [15:0] res_at(input int i);
      return (res_q.size() > i) ? res_q[i] : 16'hFFFF;
   endfunction

   function automatic logic [63:0] outs();
      return {cmd_valid, cmd_sop, cmd_eop, cmd_channel, result_valid, result_index,
              result_data, scan_done, busy, err_timeout};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   task automatic clear_mon();
      res_q.delete();
      cmd_log.delete();
      data_q.delete();
      accepted = 0;
      done_cnt = 0;
      rsp_sent = 0;
   endtask

   task automatic load4(input logic [11:0] a, b, c, d);
      data_q.push_back(a); data_q.push_back(b); data_q.push_back(c); data_q.push_back(d);
   endtask

   task automatic wait_done(input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_clk);
         if (scan_done) begin
            ok = 1'b1;
            break;
         end
      end
      enable = 1'b0;
      tick(2);
   endtask

   task automatic wait_cmd(input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk_clk);
         if (cmd_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      logic ok;
      int   bad;
      reset_reset = 1'b1;
      enable      = 1'b0;
      ch_mask     = 8'h00;
      err_clear   = 1'b0;
      cmd_ready   = 1'b1;
      tick(3);
      @(negedge clk_clk);
      check("reset_outputs", outs(), 64'd0);
      @(posedge clk_clk); #1;
      reset_reset = 1'b0;
      tick(2);

      // Basic scan of logical channels 0 and 2
      clear_mon();
      load4(12'h100, 12'h102, 12'h104, 12'h106);
      load4(12'h100, 12'h102, 12'h104, 12'h106);
      ch_mask = 8'h05; enable = 1'b1;
      wait_done(400, ok);
      check("scan1_done_seen", ok, 1);
      check("scan1_done_cnt", done_cnt, 1);
      check("scan1_cmd_count", cmd_log.size(), 8);
      for (int i = 0; i < cmd_log.size(); i++)
         check("scan1_cmd_channel", cmd_log[i], (i < 4) ? 5'd1 : 5'd3);
      check("scan1_res_count", res_q.size(), 2);
      check("scan1_res0", res_at(0), 16'h0103);
      check("scan1_res1", res_at(1), 16'h2103);
      check("scan1_idle_busy", busy, 0);

      // Command stall: fields stable while cmd_ready is low; all-0xFFF average
      clear_mon();
      load4(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      cmd_ready = 1'b0;
      ch_mask = 8'h01; enable = 1'b1;
      wait_cmd(50, ok);
      check("stall_cmd_seen", ok, 1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_clk);
         if (!cmd_valid || cmd_channel != 5'd1) bad++;
      end
      check("stall_stable", bad, 0);
      check("stall_none_accepted", accepted, 0);
      @(posedge clk_clk); #1;
      cmd_ready = 1'b1;
      @(posedge clk_clk); #1;
      check("stall_accept_once", accepted, 1);
      check("stall_valid_drop", cmd_valid, 0);
      wait_done(400, ok);
      check("stall_done_seen", ok, 1);
      check("stall_res_count", res_q.size(), 1);
      check("full_scale_avg", res_at(0), 16'h0FFF);

      // Timeout on ADC channel 2 (logical 1), scan continues to channel 3
      clear_mon();
      drop_ch = 5'd2;
      load4(12'h200, 12'h200, 12'h201, 12'h203);
      load4(12'h010, 12'h020, 12'h030, 12'h040);
      ch_mask = 8'h07; enable = 1'b1;
      wait_done(2000, ok);
      check("tmo_done_seen", ok, 1);
      check("tmo_err_set", err_timeout, 1);
      check("tmo_err_latency", err_cyc - hs_cyc, 257);
      check("tmo_cmd_count", cmd_log.size(), 9);
      check("tmo_res_count", res_q.size(), 2);
      check("tmo_res0", res_at(0), 16'h0201);
      check("tmo_res1", res_at(1), 16'h2028);
      drop_ch = 5'd0;
      err_clear = 1'b1;
      tick(1);
      err_clear = 1'b0;
      check("err_clear", err_timeout, 0);

      // Stray channel-7 response before each real one is ignored
      clear_mon();
      stray_en = 1'b1;
      load4(12'h100, 12'h102, 12'h104, 12'h106);
      ch_mask = 8'h01; enable = 1'b1;
      wait_done(400, ok);
      stray_en = 1'b0;
      check("stray_done_seen", ok, 1);
      check("stray_res_count", res_q.size(), 1);
      check("stray_res0", res_at(0), 16'h0103);

      // Empty mask: nothing happens
      clear_mon();
      ch_mask = 8'h00; enable = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_clk);
         if (busy || cmd_valid || scan_done) bad++;
      end
      enable = 1'b0;
      tick(1);
      check("zero_mask_quiet", bad, 0);
      check("zero_mask_cmds", accepted, 0);
      check("zero_mask_done", done_cnt, 0);

      // Enable dropped mid-scan: current channel finishes, no scan_done
      clear_mon();
      load4(12'h100, 12'h102, 12'h104, 12'h106);
      ch_mask = 8'h05; enable = 1'b1;
      wait_cmd(50, ok);
      check("drop_en_cmd_seen", ok, 1);
      enable = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      tick(2);
      check("drop_en_idle", ok, 1);
      check("drop_en_res_count", res_q.size(), 1);
      check("drop_en_res0", res_at(0), 16'h0103);
      check("drop_en_no_done", done_cnt, 0);

      // Reset during WAIT: outputs cleared, late response ignored
      clear_mon();
      load4(12'h555, 12'h555, 12'h555, 12'h555);
      ch_mask = 8'h01; enable = 1'b1;
      wait_cmd(50, ok);
      check("rstw_cmd_seen", ok, 1);
      @(posedge clk_clk); #1;
      reset_reset = 1'b1;
      enable = 1'b0;
      @(posedge clk_clk); #1;
      check("rstw_outputs", outs(), 64'd0);
      reset_reset = 1'b0;
      tick(10);
      check("rstw_late_rsp_sent", rsp_sent, 1);
      check("rstw_no_result", res_q.size(), 0);
      check("rstw_idle", busy, 0);

      check("sop_eop_track_valid", sop_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
